// File: rtl/muldiv_pkg.sv
// Shared muldiv definitions: signedness encodings, FSM states, operand extension helper.
// Latency: n/a (package).
// Backpressure: n/a.
package muldiv_pkg;

    // mul_signed encodings: [1] multiplicand signed, [0] multiplier signed
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_US = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fill bit used when widening an operand: its msb when that operand is
    // signed in this mode, zero otherwise.
    function automatic logic ext_fill(input logic [1:0] mode, input logic is_mcand,
                                      input logic msb);
        return (is_mcand ? mode[1] : mode[0]) & msb;
    endfunction

endpackage

// File: rtl/mul_iter_param_if.sv
// Request/response bundle between the EXU and the iterative multiplier.
// Latency: n/a (wiring only).
// Backpressure: requester holds mul_valid until it sees mul_ready on an edge.
interface mul_iter_param_if #(
    parameter int XLEN = 64
);
    logic            mul_valid;
    logic            flush;
    logic            mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            mul_ready;
    logic            out_valid;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    modport master (
        output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
        input  mul_ready, out_valid, result_hi, result_lo
    );

    modport slave (
        input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
        output mul_ready, out_valid, result_hi, result_lo
    );
endinterface

// File: rtl/mul_step_adder.sv
// Accumulates STEP shifted copies of the multiplicand selected by the low multiplier bits.
// Latency: combinational.
// Backpressure: none.
module mul_step_adder #(
    parameter int XLEN = 64,
    parameter int STEP = 2
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [STEP-1:0]   bits,
    output logic [2*XLEN-1:0] acc_nxt
);

    // Sum of acc and (mcand << k) for every set bit k
    always_comb begin
        acc_nxt = acc;
        for (int k = 0; k < STEP; k++) begin
            if (bits[k]) begin
                acc_nxt = acc_nxt + (mcand << k);
            end
        end
    end

endmodule

// File: rtl/mul_iter_param.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle, with sign-bit early-out.
// Latency: iterations+2 cycles from accept to out_valid (2 when the multiplier is 0 / -1).
// Backpressure: one operation in flight; mul_ready low from accept until back in IDLE.
module mul_iter_param
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64,   // even, >= 8
    parameter int STEP = 2     // 1, 2 or 4; divides XLEN/2
) (
    input  logic            clk,
    input  logic            rst,
    mul_iter_param_if.slave bus
);

    localparam int HALF = XLEN / 2;

    state_t              state;
    state_t              state_nxt;
    logic [2*XLEN-1:0]   mcand;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   acc_nxt;
    logic [2*XLEN-1:0]   product;
    logic [2*XLEN-1:0]   mcand_ld;
    logic [XLEN:0]       mplr;      // one guard bit so unsigned full-width operands stay positive
    logic [XLEN:0]       mplr_ld;
    logic                wmode;
    logic                accept;
    logic                mplr_ones;
    logic                term;
    logic                a_fill;
    logic                b_fill;
    logic [XLEN-1:0]     res_hi;
    logic [XLEN-1:0]     res_lo;

    assign bus.result_hi = res_hi;
    assign bus.result_lo = res_lo;

    // Widen operands for loading: multiplicand to 2*XLEN, multiplier to the register width
    always_comb begin
        a_fill = ext_fill(bus.mul_signed, 1'b1,
                          bus.mulw ? bus.multiplicand[HALF-1] : bus.multiplicand[XLEN-1]);
        b_fill = ext_fill(bus.mul_signed, 1'b0,
                          bus.mulw ? bus.multiplier[HALF-1] : bus.multiplier[XLEN-1]);
        if (bus.mulw) begin
            mcand_ld = {{(2*XLEN-HALF){a_fill}}, bus.multiplicand[HALF-1:0]};
            mplr_ld  = {{(XLEN+1-HALF){b_fill}}, bus.multiplier[HALF-1:0]};
        end else begin
            mcand_ld = {{XLEN{a_fill}}, bus.multiplicand};
            mplr_ld  = {b_fill, bus.multiplier};
        end
    end

    // Remaining multiplier is 0 or -1: the product is known this cycle
    always_comb begin
        mplr_ones = &mplr;
        term      = (mplr == '0) || mplr_ones;
        product   = mplr_ones ? (acc - mcand) : acc;
    end

    mul_step_adder #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .acc     (acc),
        .mcand   (mcand),
        .bits    (mplr[STEP-1:0]),
        .acc_nxt (acc_nxt)
    );

    // Next state and handshake outputs; flush wins over every transition
    always_comb begin
        state_nxt     = state;
        bus.mul_ready = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.mul_ready = !bus.flush && !rst;
                accept        = bus.mul_valid && !bus.flush && !rst;
                if (accept) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (term) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = !bus.flush && !rst;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand load, per-cycle shift/accumulate, and result capture on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            wmode  <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else if (accept) begin
            mcand  <= mcand_ld;
            mplr   <= mplr_ld;
            acc    <= '0;
            wmode  <= bus.mulw;
        end else if (state == BUSY && !bus.flush) begin
            if (term) begin
                if (wmode) begin
                    res_lo <= product[XLEN-1:0];
                    res_hi <= {XLEN{product[XLEN-1]}};
                end else begin
                    res_lo <= product[XLEN-1:0];
                    res_hi <= product[2*XLEN-1:XLEN];
                end
            end else begin
                acc   <= acc_nxt;
                mplr  <= $unsigned($signed(mplr) >>> STEP);
                mcand <= mcand << STEP;
            end
        end
    end

endmodule

// File: tb/tb_mul_iter_param.sv
// Drives three multiplier builds (STEP=1,2,4) in lockstep against a 128-bit reference.
// Latency: checks iterations+2 per build from the reference iteration count.
// Backpressure: requests issued only when all three builds show mul_ready.
module tb_mul_iter_param;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam int NDUT = 3;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mul_valid = 1'b0;
    logic            flush = 1'b0;
    logic            mulw = 1'b0;
    logic [1:0]      mul_signed = 2'b00;
    logic [63:0]     mcand_in = '0;
    logic [63:0]     mplr_in = '0;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] ov;
    logic [63:0]     hi_o[NDUT];
    logic [63:0]     lo_o[NDUT];
    exp_t            q[NDUT][$];
    logic [63:0]     corner[16];
    int              cyc = 0;
    int              tests = 0;
    int              fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int ST = 1 << g;
        mul_iter_param_if #(.XLEN(XLEN)) bus ();
        assign bus.mul_valid    = mul_valid;
        assign bus.flush        = flush;
        assign bus.mulw         = mulw;
        assign bus.mul_signed   = mul_signed;
        assign bus.multiplicand = mcand_in;
        assign bus.multiplier   = mplr_in;
        assign rdy[g]  = bus.mul_ready;
        assign ov[g]   = bus.out_valid;
        assign hi_o[g] = bus.result_hi;
        assign lo_o[g] = bus.result_lo;

        mul_iter_param #(.XLEN(XLEN), .STEP(ST)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Monitor: every out_valid must match the oldest outstanding expectation
        always @(negedge clk) begin : mon
            exp_t e;
            int   lat;
            if (!rst && bus.out_valid) begin
                tests++;
                if (q[g].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid step%0d cyc %0d: got 1 required 0", ST, cyc);
                end else begin
                    e = q[g].pop_front();
                    if (bus.result_hi !== e.hi || bus.result_lo !== e.lo) begin
                        fails++;
                        $display("FAIL result step%0d: got %h_%h required %h_%h",
                                 ST, bus.result_hi, bus.result_lo, e.hi, e.lo);
                    end
                    lat = cyc - e.acc_cyc + 1;
                    tests++;
                    if (lat != e.lat) begin
                        fails++;
                        $display("FAIL latency step%0d: got %0d required %0d", ST, lat, e.lat);
                    end
                end
            end
        end
    end

    // Operand as the signed 128-bit value it represents in the given mode
    function automatic logic signed [127:0] ext(input logic [63:0] v, input bit word, input bit sgn);
        logic [127:0] r;
        if (word) r = sgn ? {{96{v[31]}}, v[31:0]} : {96'b0, v[31:0]};
        else      r = sgn ? {{64{v[63]}}, v} : {64'b0, v};
        return $signed(r);
    endfunction

    // Reference product as {hi, lo}
    function automatic logic [127:0] ref_prod(input logic [1:0] mode, input bit word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = ext(a, word, mode[1]) * ext(b, word, mode[0]);
        if (word) return {{64{p[63]}}, p[63:0]};
        return p;
    endfunction

    // Chunks of `step` bits consumed before the rest of the multiplier is 0 or -1
    function automatic int iters(input logic signed [127:0] b, input int step);
        int n = 0;
        while (b != '0 && ~b != '0) begin
            b = b >>> step;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Present one request to all builds; returns one cycle... #1 after the accept edge
    task automatic issue(input logic [1:0] mode, input bit word, input logic [63:0] a,
                         input logic [63:0] b, input bit chk);
        int           waited = 0;
        exp_t         e;
        logic [127:0] p;
        @(negedge clk);
        while (rdy != '1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (rdy != '1) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got mul_ready=%b required 111", rdy);
            return;
        end
        mul_valid  = 1'b1;
        mul_signed = mode;
        mulw       = word;
        mcand_in   = a;
        mplr_in    = b;
        @(posedge clk);
        #1;
        mul_valid  = 1'b0;
        mcand_in   = {$urandom, $urandom};
        mplr_in    = {$urandom, $urandom};
        mulw       = 1'($urandom);
        mul_signed = 2'($urandom);
        if (chk) begin
            p = ref_prod(mode, word, a, b);
            for (int i = 0; i < NDUT; i++) begin
                e.hi      = p[127:64];
                e.lo      = p[63:0];
                e.lat     = iters(ext(b, word, mode[0]), 1 << i) + 2;
                e.acc_cyc = cyc;
                q[i].push_back(e);
            end
        end
    endtask

    initial begin
        logic [127:0] p;
        int           waited;
        corner[0]  = 64'h0;                   corner[1]  = 64'h1;
        corner[2]  = 64'h2;                   corner[3]  = 64'h3;
        corner[4]  = 64'hFFFFFFFF_FFFFFFFF;   corner[5]  = 64'hFFFFFFFF_FFFFFFFE;
        corner[6]  = 64'h7FFFFFFF_FFFFFFFF;   corner[7]  = 64'h80000000_00000000;
        corner[8]  = 64'h00000000_7FFFFFFF;   corner[9]  = 64'h00000000_80000000;
        corner[10] = 64'hFFFFFFFF_80000000;   corner[11] = 64'hFFFFFFFF_00000000;
        corner[12] = 64'h00000000_FFFFFFFF;   corner[13] = 64'h55555555_55555555;
        corner[14] = 64'hAAAAAAAA_AAAAAAAA;   corner[15] = 64'h12345678_9ABCDEF0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_ready[%0d]", i), 64'(rdy[i]), 64'd0);
            check($sformatf("reset_out_valid[%0d]", i), 64'(ov[i]), 64'd0);
            check($sformatf("reset_hi[%0d]", i), hi_o[i], 64'd0);
            check($sformatf("reset_lo[%0d]", i), lo_o[i], 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors
        issue(MUL_SS, 1'b0, 64'd5, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        issue(MUL_UU, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        issue(MUL_SU, 1'b1, 64'h00000000_80000000, 64'h00000000_FFFFFFFF, 1'b1);
        issue(MUL_SS, 1'b0, 64'h80000000_00000000, 64'h80000000_00000000, 1'b1);

        // Flush raised during DONE suppresses out_valid; results were already captured
        issue(MUL_SS, 1'b0, 64'd5, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        p = ref_prod(MUL_SS, 1'b0, 64'd5, 64'hFFFFFFFF_FFFFFFFF);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("flush_done_out_valid[%0d]", i), 64'(ov[i]), 64'd0);
            check($sformatf("flush_done_lo[%0d]", i), lo_o[i], p[63:0]);
        end
        @(posedge clk);
        #1 flush = 1'b0;

        // Flush in the first BUSY cycle: abort, ready again one cycle later
        issue(MUL_UU, 1'b0, 64'd7, 64'd3, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("flush_busy_ready[%0d]", i), 64'(rdy[i]), 64'd1);
            check($sformatf("flush_busy_lo_held[%0d]", i), lo_o[i], p[63:0]);
        end
        issue(MUL_SS, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFB, 1'b1);

        // mul_valid together with flush must not be accepted
        @(negedge clk);
        while (rdy != '1) @(negedge clk);
        mul_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("flush_with_valid_ready", 64'(rdy), 64'(3'b111));

        // Corner/random sweep over every mode, full and word width
        for (int m = 0; m < 4; m++) begin
            for (int w = 0; w < 2; w++) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < 6)
                        issue(2'(m), 1'(w), corner[$urandom_range(15, 0)],
                              corner[$urandom_range(15, 0)], 1'b1);
                    else
                        issue(2'(m), 1'(w), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
                end
            end
        end

        // Drain outstanding expectations (bounded)
        waited = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end

        // Reset in the middle of BUSY: no out_valid, outputs cleared
        issue(MUL_UU, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 64'(rdy), 64'd0);
        check("rst_mid_out_valid", 64'(ov), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_mid_hi[%0d]", i), hi_o[i], 64'd0);
            check($sformatf("rst_mid_lo[%0d]", i), lo_o[i], 64'd0);
            check($sformatf("rst_mid_ready_after[%0d]", i), 64'(rdy[i]), 64'd1);
        end
        repeat (80) @(posedge clk);

        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("queue_empty[%0d]", i), 64'(q[i].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
